// File: rtl/sudoku_link_pkg.sv
// Shared constants and state encoding for the sudoku board nibble link transmitter.
package sudoku_link_pkg;
   localparam int CELLS     = 81;
   localparam int FRAME_LEN = 82;
   localparam int IDX_W     = 7;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_SETUP = 3'd2,
      ST_VHI   = 3'd3,
      ST_VLO   = 3'd4,
      ST_DONE  = 3'd5
   } state_e;
endpackage

// File: rtl/link_sync.sv
// Two-flop synchronizer for a single asynchronous level input.
module link_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta_q;
   logic sync_q;

   // NOTE: sequential state uses non-blocking assignments so both stages shift on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/sudoku_link_tx.sv
// Sends an 82-nibble frame (header + 81 board cells) over a four-phase valid/ack link.
// Optional ack watchdog with err output is enabled by defining LINK_TIMEOUT_EN.
module sudoku_link_tx
   import sudoku_link_pkg::*;
#(
   parameter int SETUP_CYC   = 2,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             request,
   input  logic             ack_in,
   input  logic [3:0]       hdr,
   output logic [IDX_W-1:0] cell_addr,
   input  logic [3:0]       cell_data,
   output logic             ack_out,
   output logic [3:0]       data,
   output logic             valid,
   output logic             busy,
   output logic             frame_done
`ifdef LINK_TIMEOUT_EN
   ,
   output logic             err
`endif
);
   localparam int SW = $clog2(SETUP_CYC + 1);

   if (SETUP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("sudoku_link_tx: SETUP_CYC and TIMEOUT_CYC must be at least 1");
   end

   logic req_s;
   logic ack_s;

   link_sync u_req_sync (.clk(clk), .rst_n(rst_n), .d(request), .q(req_s));
   link_sync u_ack_sync (.clk(clk), .rst_n(rst_n), .d(ack_in),  .q(ack_s));

   state_e           state_q,     state_d;
   logic [IDX_W-1:0] index_q,     index_d;
   logic [3:0]       data_q,      data_d;
   logic             valid_q,     valid_d;
   logic             ack_out_q,   ack_out_d;
   logic             done_q,      done_d;
   logic             fetch_ph_q,  fetch_ph_d;
   logic [SW-1:0]    setup_cnt_q, setup_cnt_d;
   logic             tmo_hit;

`ifdef LINK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;

   assign tmo_hit = (state_q inside {ST_VHI, ST_VLO}) && (tmo_q == TW'(TIMEOUT_CYC - 1));

   // The watchdog restarts whenever the FSM changes state, so VHI and VLO are timed separately.
   always_comb begin
      err_d = tmo_hit;
      if (state_d != state_q)                  tmo_d = '0;
      else if (state_q inside {ST_VHI, ST_VLO}) tmo_d = tmo_q + TW'(1);
      else                                      tmo_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign tmo_hit = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      data_d      = data_q;
      valid_d     = valid_q;
      ack_out_d   = ack_out_q;
      done_d      = 1'b0;
      fetch_ph_d  = 1'b0;
      setup_cnt_d = setup_cnt_q;

      case (state_q)
         ST_IDLE: if (req_s) begin
            data_d      = hdr;
            index_d     = '0;
            ack_out_d   = 1'b1;
            setup_cnt_d = '0;
            state_d     = ST_SETUP;
         end
         // First FETCH cycle presents the address, second captures the synchronous read.
         ST_FETCH: if (!fetch_ph_q) begin
            fetch_ph_d = 1'b1;
         end else begin
            data_d      = cell_data;
            setup_cnt_d = '0;
            state_d     = ST_SETUP;
         end
         ST_SETUP: if (setup_cnt_q == SW'(SETUP_CYC - 1)) begin
            valid_d = 1'b1;
            state_d = ST_VHI;
         end else begin
            setup_cnt_d = setup_cnt_q + SW'(1);
         end
         ST_VHI: if (ack_s) begin
            valid_d = 1'b0;
            state_d = ST_VLO;
         end
         ST_VLO: if (!ack_s) begin
            if (index_q == LAST_IDX) begin
               done_d    = 1'b1;
               ack_out_d = 1'b0;
               state_d   = ST_DONE;
            end else begin
               index_d = (index_q == LAST_IDX) ? LAST_IDX : index_q + IDX_W'(1);
               state_d = ST_FETCH;
            end
         end
         ST_DONE: if (!req_s) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Peer withdrawal or watchdog expiry drops the frame without frame_done.
      if (((state_q inside {ST_SETUP, ST_VHI, ST_VLO}) && !req_s) || tmo_hit) begin
         valid_d   = 1'b0;
         ack_out_d = 1'b0;
         done_d    = 1'b0;
         state_d   = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         index_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         ack_out_q   <= 1'b0;
         done_q      <= 1'b0;
         fetch_ph_q  <= 1'b0;
         setup_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ack_out_q   <= ack_out_d;
         done_q      <= done_d;
         fetch_ph_q  <= fetch_ph_d;
         setup_cnt_q <= setup_cnt_d;
      end
   end

   assign cell_addr  = (state_q == ST_FETCH && !fetch_ph_q) ? index_q - IDX_W'(1) : '0;
   assign data       = data_q;
   assign valid      = valid_q;
   assign ack_out    = ack_out_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = done_q;
endmodule

// File: tb/tb_sudoku_link_tx.sv
// Randomized peer/board-memory bench for sudoku_link_tx; frames are checked against
// the expected nibble sequence {hdr, cell[0..80]} built from a behavioural memory model.
module tb_sudoku_link_tx;
   import sudoku_link_pkg::*;

   localparam int SETUP = 3;
   localparam int TMO   = 100;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             request = 1'b0;
   logic             ack_in = 1'b0;
   logic [3:0]       hdr = 4'h0;
   logic [IDX_W-1:0] cell_addr;
   logic [3:0]       cell_data;
   logic             ack_out;
   logic [3:0]       data;
   logic             valid;
   logic             busy;
   logic             frame_done;
`ifdef LINK_TIMEOUT_EN
   logic             err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int fd_cnt = 0;
   int vrise_cnt = 0;

   logic [3:0] mem [CELLS];
   logic [3:0] rd_q;

   always #5 clk = ~clk;

   // Synchronous-read board memory: data valid one cycle after the address.
   always @(posedge clk) rd_q <= mem[cell_addr];
   assign cell_data = rd_q;

   sudoku_link_tx #(.SETUP_CYC(SETUP), .TIMEOUT_CYC(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .request    (request),
      .ack_in     (ack_in),
      .hdr        (hdr),
      .cell_addr  (cell_addr),
      .cell_data  (cell_data),
      .ack_out    (ack_out),
      .data       (data),
      .valid      (valid),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef LINK_TIMEOUT_EN
      ,
      .err        (err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Link-protocol monitor: data held while valid (and as it falls), setup time before each rise.
   logic       prev_valid = 1'b0;
   logic [3:0] prev_data = 4'h0;
   int         run = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_data  = data;
         run        = 0;
      end else begin
         if (frame_done) fd_cnt++;
         if (prev_valid) check("hold", data, prev_data);
         if (valid) check("addr_idle", cell_addr, 0);
         if (valid && !prev_valid) begin
            vrise_cnt++;
            check("setup_run", (run >= SETUP) ? SETUP : run, SETUP);
         end
         run        = (data === prev_data) ? run + 1 : 1;
         prev_data  = data;
         prev_valid = valid;
      end
   end

   function automatic logic [3:0] exp_nib(int k, logic [3:0] h);
      return (k == 0) ? h : mem[k-1];
   endfunction

   task automatic fill_mem(input bit rnd);
      for (int i = 0; i < CELLS; i++) mem[i] = rnd ? 4'($urandom_range(0, 15)) : 4'(i % 10);
   endtask

   task automatic wait_valid(input logic lvl, input string tag, output bit ok);
      int n = 0;
      ok = 1'b1;
      while (valid !== lvl) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            check(tag, valid, lvl);
            ok = 1'b0;
            return;
         end
      end
   endtask

   task automatic send_nibble(input logic [3:0] exp, input string tag, output bit ok);
      wait_valid(1'b1, {tag, "_rise_timeout"}, ok);
      if (!ok) return;
      check(tag, data, exp);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack_in = 1'b1;
      wait_valid(1'b0, {tag, "_fall_timeout"}, ok);
      ack_in = 1'b0;
   endtask

   task automatic run_nibbles(input int first, input int last, input logic [3:0] h, output bit ok);
      ok = 1'b1;
      for (int k = first; k <= last; k++) begin
         send_nibble(exp_nib(k, h), $sformatf("nib%0d", k), ok);
         if (!ok) return;
      end
   endtask

   task automatic full_frame(input string tag);
      int  fd0;
      bit  ok;
      fd0 = fd_cnt;
      request = 1'b1;
      run_nibbles(0, FRAME_LEN - 1, hdr, ok);
      repeat (5) @(negedge clk);
      check({tag, "_frame_done_cnt"}, fd_cnt - fd0, 1);
      check({tag, "_ack_out_low"}, ack_out, 1'b0);
      check({tag, "_busy_in_done"}, busy, 1'b1);
   endtask

   task automatic drop_request(input string tag);
      request = 1'b0;
      repeat (4) @(negedge clk);
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      int fd0;
      int vr0;
      bit ok;

      fill_mem(1'b0);
      hdr = 4'h5;
      repeat (3) @(negedge clk);
      check("rst_ack_out", ack_out, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_data", data, 4'h0);
      check("rst_cell_addr", cell_addr, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_no_request", busy, 1'b0);

      // Reference frame: hdr 5, cells i%10.
      full_frame("ref");
      drop_request("ref");

      for (int f = 0; f < 2; f++) begin
         fill_mem(1'b1);
         hdr = 4'($urandom_range(0, 15));
         full_frame($sformatf("rnd%0d", f));
         drop_request($sformatf("rnd%0d", f));
      end

      // Abort after nibble 10 is fully acknowledged.
      fill_mem(1'b1);
      hdr = 4'hA;
      fd0 = fd_cnt;
      request = 1'b1;
      run_nibbles(0, 10, hdr, ok);
      request = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_valid", valid, 1'b0);
      check("abort_ack_out", ack_out, 1'b0);
      check("abort_idle", busy, 1'b0);
      vr0 = vrise_cnt;
      repeat (30) @(negedge clk);
      check("abort_no_frame_done", fd_cnt - fd0, 0);
      check("abort_quiet", vrise_cnt - vr0, 0);

      // Reset during VHI of nibble 40, then a fresh frame from the header.
      hdr = 4'h3;
      request = 1'b1;
      run_nibbles(0, 39, hdr, ok);
      wait_valid(1'b1, "rst40_rise_timeout", ok);
      rst_n = 1'b0;
      #1;
      check("rst40_ack_out", ack_out, 1'b0);
      check("rst40_valid", valid, 1'b0);
      check("rst40_data", data, 4'h0);
      check("rst40_cell_addr", cell_addr, 0);
      check("rst40_busy", busy, 1'b0);
      check("rst40_frame_done", frame_done, 1'b0);
      hdr = 4'h9;
      @(negedge clk);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      full_frame("post_rst");

      // Request held high past DONE must not start a second frame.
      vr0 = vrise_cnt;
      repeat (200) @(negedge clk);
      check("rereq_no_valid", vrise_cnt - vr0, 0);
      check("rereq_busy_done", busy, 1'b1);
      drop_request("rereq");
      fill_mem(1'b1);
      hdr = 4'($urandom_range(0, 15));
      full_frame("rereq");
      drop_request("rereq_end");

`ifdef LINK_TIMEOUT_EN
      begin
         int n;
         n = 0;
         request = 1'b1;
         wait_valid(1'b1, "tmo_rise_timeout", ok);
         while (err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
         end
         check("tmo_cycles", n, TMO);
         check("tmo_valid", valid, 1'b0);
         check("tmo_idle", busy, 1'b0);
         request = 1'b0;
         repeat (6) @(negedge clk);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
